// File: rtl/simple_ctrl_fsm_if.sv
// Signal bundle between the instruction-sequencing FSM and its datapath/memory.
// There is no valid/ready pair: i_run is a level qualifier, and every o_* strobe is a one-cycle pulse.
interface simple_ctrl_fsm_if;
    logic       i_run;
    logic [7:0] i_instr;
    logic       i_zero;
    logic       o_pc_en;
    logic       o_pc_set_;
    logic [3:0] o_pc_value;
    logic [7:0] o_ir;
    logic       o_ld_a;
    logic [1:0] o_alu_op;
    logic       o_ld_out;
    logic       o_halted;
    logic [2:0] o_state;

    modport slave (
        input  i_run, i_instr, i_zero,
        output o_pc_en, o_pc_set_, o_pc_value, o_ir, o_ld_a, o_alu_op,
               o_ld_out, o_halted, o_state
    );

    modport master (
        output i_run, i_instr, i_zero,
        input  o_pc_en, o_pc_set_, o_pc_value, o_ir, o_ld_a, o_alu_op,
               o_ld_out, o_halted, o_state
    );
endinterface

// File: rtl/simple_ctrl_fsm.sv
// Fetch/decode/execute sequencer for a tiny accumulator machine.
// Outputs decode from the registered state and instruction register; only JZ looks at a live input.
module simple_ctrl_fsm (
    input  logic                  i_clk,
    input  logic                  i_rst,
    simple_ctrl_fsm_if.slave      bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] ir;
    logic       pc_en;
    logic       pc_set_n;
    logic [3:0] pc_value;
    logic       ld_a;
    logic [1:0] alu_op;
    logic       ld_out;

    wire [3:0] opcode  = ir[7:4];
    wire [3:0] operand = ir[3:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ir    <= 8'h00;
        end else begin
            state <= next_state;
            if (state == ST_FETCH) ir <= bus.i_instr;
        end
    end

    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        pc_set_n   = 1'b1;
        pc_value   = 4'h0;
        ld_a       = 1'b0;
        alu_op     = 2'b00;
        ld_out     = 1'b0;
        case (state)
            ST_IDLE:   if (bus.i_run) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                // i_run is consulted only here, so a drop mid-instruction never aborts it
                next_state = bus.i_run ? ST_FETCH : ST_IDLE;
                case (opcode)
                    4'h1: begin ld_a = 1'b1; alu_op = 2'b00; pc_en = 1'b1; end
                    4'h2: begin ld_a = 1'b1; alu_op = 2'b01; pc_en = 1'b1; end
                    4'h3: begin ld_a = 1'b1; alu_op = 2'b10; pc_en = 1'b1; end
                    4'h4: begin pc_set_n = 1'b0; pc_value = operand; end
                    4'h5: begin
                        if (bus.i_zero) begin
                            pc_set_n = 1'b0;
                            pc_value = operand;
                        end else begin
                            pc_en = 1'b1;
                        end
                    end
                    4'h6: begin ld_out = 1'b1; pc_en = 1'b1; end
                    4'hF: next_state = ST_HALT;
                    default: pc_en = 1'b1;
                endcase
            end
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign bus.o_pc_en    = pc_en;
    assign bus.o_pc_set_  = pc_set_n;
    assign bus.o_pc_value = pc_value;
    assign bus.o_ir       = ir;
    assign bus.o_ld_a     = ld_a;
    assign bus.o_alu_op   = alu_op;
    assign bus.o_ld_out   = ld_out;
    assign bus.o_halted   = (state == ST_HALT);
    assign bus.o_state    = state;
endmodule

// File: tb/tb_simple_ctrl_fsm.sv
// Directed and random checking of simple_ctrl_fsm against an instruction-level reference model.
module tb_simple_ctrl_fsm;
    logic i_clk;
    logic i_rst;
    simple_ctrl_fsm_if bus ();

    simple_ctrl_fsm dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: machine mode (0 idle, 1 running, 2 halted), phase within the 3-cycle instruction, latched word
    int         m_mode;
    int         m_phase;
    logic [7:0] m_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int         op;
        logic       execing, jump, hlt;
        int         e_state;
        op      = int'(m_word[7:4]);
        execing = (m_mode == 1) && (m_phase == 2);
        jump    = execing && (op == 4 || (op == 5 && bus.i_zero === 1'b1));
        hlt     = execing && (op == 15);
        e_state = (m_mode == 2) ? 4 : (m_mode == 0) ? 0 : m_phase + 1;
        check("state",    32'(bus.o_state),    32'(e_state));
        check("halted",   32'(bus.o_halted),   32'(m_mode == 2));
        check("ir",       32'(bus.o_ir),       32'(m_word));
        check("pc_en",    32'(bus.o_pc_en),    32'(execing && !jump && !hlt));
        check("pc_set_",  32'(bus.o_pc_set_),  32'(!jump));
        check("pc_value", 32'(bus.o_pc_value), jump ? 32'(m_word[3:0]) : 32'd0);
        check("ld_a",     32'(bus.o_ld_a),     32'(execing && op >= 1 && op <= 3));
        check("alu_op",   32'(bus.o_alu_op),   execing ? ((op == 2) ? 32'd1 : (op == 3) ? 32'd2 : 32'd0) : 32'd0);
        check("ld_out",   32'(bus.o_ld_out),   32'(execing && op == 6));
        check("pc_excl",  32'(bus.o_pc_en && !bus.o_pc_set_), 32'd0);
    endtask

    task automatic model_step(input logic rst, input logic run, input logic [7:0] instr);
        if (rst) begin
            m_mode = 0; m_phase = 0; m_word = 8'h00;
        end else if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_phase = 0; end
        end else if (m_mode == 1) begin
            if (m_phase == 0) begin
                m_word  = instr;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_word[7:4] == 4'hF) begin
                m_mode = 2;
            end else if (run) begin
                m_phase = 0;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance model with the clock
    task automatic cycle(input logic rst, input logic run, input logic [7:0] instr, input logic zero);
        i_rst       = rst;
        bus.i_run   = run;
        bus.i_instr = instr;
        bus.i_zero  = zero;
        @(negedge i_clk);
        check_outputs();
        @(posedge i_clk);
        model_step(rst, run, instr);
        #1;
    endtask

    task automatic run_instr(input logic [7:0] instr, input logic zero);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, instr, zero);
    endtask

    initial begin
        i_rst = 1'b1; bus.i_run = 1'b0; bus.i_instr = 8'h00; bus.i_zero = 1'b0;
        @(posedge i_clk);
        model_step(1'b1, 1'b0, 8'h00);
        #1;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // NOP stream: 1,2,3 repeating with a single pc_en per instruction
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        run_instr(8'h4A, 1'b0);
        run_instr(8'h53, 1'b1);
        run_instr(8'h53, 1'b0);
        run_instr(8'h21, 1'b0);
        run_instr(8'h31, 1'b0);
        run_instr(8'h6F, 1'b0);
        run_instr(8'h9C, 1'b1);

        // Sync to FETCH, drop run in DECODE, EXEC completes and lands in IDLE
        while (m_mode != 1 || m_phase != 0) cycle(1'b0, 1'b1, 8'h21, 1'b0);
        cycle(1'b0, 1'b1, 8'h21, 1'b0);
        cycle(1'b0, 1'b0, 8'h21, 1'b0);
        cycle(1'b0, 1'b0, 8'h21, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_after_drop", 32'(bus.o_state), 32'd0);

        // Reset asserted during EXEC
        cycle(1'b0, 1'b1, 8'h4A, 1'b0);
        cycle(1'b0, 1'b1, 8'h4A, 1'b0);
        cycle(1'b0, 1'b1, 8'h4A, 1'b0);
        cycle(1'b1, 1'b1, 8'h4A, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_mid_exec", 32'(bus.o_state), 32'd0);

        // HLT holds regardless of i_run, only reset leaves
        cycle(1'b0, 1'b1, 8'hF0, 1'b0);
        run_instr(8'hF0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b1, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 7) != 0),
                  8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
